// File: rtl/pagerank_pkg.sv
// Shared types and default constants for the PageRank iteration controller.
package pagerank_pkg;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned NUM_ANTS = 4;
  localparam int unsigned MAX_ITER = 400;
  localparam int unsigned EPS      = 4;

  typedef enum logic [2:0] {
    StIdle,
    StStep,
    StWait,
    StCheck,
    StSort,
    StDone
  } state_e;

endpackage

// File: rtl/pagerank_conv_check.sv
// Per-lane |probe - prev| <= EPS compare; all_stable only once a previous sweep exists.
module pagerank_conv_check #(
  parameter int unsigned WIDTH    = pagerank_pkg::WIDTH,
  parameter int unsigned NUM_ANTS = pagerank_pkg::NUM_ANTS,
  parameter int unsigned EPS      = pagerank_pkg::EPS
) (
  input  logic [NUM_ANTS*WIDTH-1:0] probe_vals,
  input  logic [NUM_ANTS*WIDTH-1:0] prev_vals,
  input  logic                      prev_valid,
  output logic                      all_stable
);

  localparam logic [WIDTH:0] EpsLim = (WIDTH+1)'(EPS);

  logic [NUM_ANTS-1:0] lane_ok;

  for (genvar i = 0; i < NUM_ANTS; i++) begin : g_lane
    logic [WIDTH:0] cur_v;
    logic [WIDTH:0] old_v;
    logic [WIDTH:0] diff;

    // Extra bit keeps the subtraction from wrapping at the 0/max boundary.
    assign cur_v      = {1'b0, probe_vals[i*WIDTH +: WIDTH]};
    assign old_v      = {1'b0, prev_vals[i*WIDTH +: WIDTH]};
    assign diff       = (cur_v >= old_v) ? (cur_v - old_v) : (old_v - cur_v);
    assign lane_ok[i] = (diff <= EpsLim);
  end

  assign all_stable = prev_valid & (&lane_ok);

endmodule

// File: rtl/pagerank_iter_ctrl.sv
// Sweep scheduler: broadcasts step_go, gathers ant completions, checks convergence, runs top10.
module pagerank_iter_ctrl #(
  parameter int unsigned WIDTH        = pagerank_pkg::WIDTH,
  parameter int unsigned NUM_ANTS     = pagerank_pkg::NUM_ANTS,
  parameter int unsigned ITER_W       = 9,
  parameter int unsigned MAX_ITER     = pagerank_pkg::MAX_ITER,
  parameter int unsigned EPS          = pagerank_pkg::EPS,
  parameter int unsigned STABLE_ITERS = 3,
  parameter int unsigned WAIT_MAX     = 1023
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic [NUM_ANTS-1:0]       ant_step_done,
  input  logic [NUM_ANTS*WIDTH-1:0] probe_vals,
  input  logic                      sort_done,
  output logic                      step_go,
  output logic                      sort_start,
  output logic                      busy,
  output logic                      done,
  output logic                      converged,
  output logic                      stall_err,
  output logic [ITER_W-1:0]         iter_count
);

  import pagerank_pkg::*;

  localparam int unsigned WdW = $clog2(WAIT_MAX + 1);
  localparam int unsigned ScW = $clog2(STABLE_ITERS + 1);

  state_e                    state_q, state_d;
  logic [NUM_ANTS-1:0]       mask_q, mask_d;
  logic [WdW-1:0]            wd_q, wd_d;
  logic [NUM_ANTS*WIDTH-1:0] prev_q, prev_d;
  logic                      prev_valid_q, prev_valid_d;
  logic [ScW-1:0]            stable_cnt_q, stable_cnt_d;
  logic [ITER_W-1:0]         iter_q, iter_d;
  logic                      conv_q, conv_d;
  logic                      stall_q, stall_d;
  logic                      sort_issued_q;
  logic                      all_stable;

  pagerank_conv_check #(
    .WIDTH    (WIDTH),
    .NUM_ANTS (NUM_ANTS),
    .EPS      (EPS)
  ) u_conv_check (
    .probe_vals (probe_vals),
    .prev_vals  (prev_q),
    .prev_valid (prev_valid_q),
    .all_stable (all_stable)
  );

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    wd_d         = wd_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    stable_cnt_d = stable_cnt_q;
    iter_d       = iter_q;
    conv_d       = conv_q;
    stall_d      = stall_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d      = StStep;
          iter_d       = '0;
          stable_cnt_d = '0;
          prev_valid_d = 1'b0;
          conv_d       = 1'b0;
          stall_d      = 1'b0;
        end
      end
      StStep: begin
        mask_d  = '0;
        wd_d    = '0;
        state_d = StWait;
      end
      StWait: begin
        mask_d = mask_q | ant_step_done;
        wd_d   = wd_q + 1'b1;
        if (&mask_d) begin
          state_d = StCheck;
        end else if (wd_d == WdW'(WAIT_MAX)) begin
          stall_d = 1'b1;
          conv_d  = 1'b0;
          state_d = StSort;
        end
      end
      StCheck: begin
        if (all_stable) begin
          stable_cnt_d = (&stable_cnt_q) ? stable_cnt_q : stable_cnt_q + 1'b1;
        end else begin
          stable_cnt_d = '0;
        end
        prev_d       = probe_vals;
        prev_valid_d = 1'b1;
        iter_d       = iter_q + 1'b1;
        if (stable_cnt_d == ScW'(STABLE_ITERS)) begin
          conv_d  = 1'b1;
          state_d = StSort;
        end else if (iter_d == ITER_W'(MAX_ITER)) begin
          conv_d  = 1'b0;
          state_d = StSort;
        end else begin
          state_d = StStep;
        end
      end
      StSort: begin
        if (sort_done) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase

    // abort overrides everything, including a simultaneous start.
    if (abort) begin
      state_d = StIdle;
      conv_d  = 1'b0;
      stall_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      mask_q        <= '0;
      wd_q          <= '0;
      prev_q        <= '0;
      prev_valid_q  <= 1'b0;
      stable_cnt_q  <= '0;
      iter_q        <= '0;
      conv_q        <= 1'b0;
      stall_q       <= 1'b0;
      sort_issued_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      wd_q          <= wd_d;
      prev_q        <= prev_d;
      prev_valid_q  <= prev_valid_d;
      stable_cnt_q  <= stable_cnt_d;
      iter_q        <= iter_d;
      conv_q        <= conv_d;
      stall_q       <= stall_d;
      sort_issued_q <= (state_q == StSort);
    end
  end

  always_comb begin
    step_go    = (state_q == StStep);
    sort_start = (state_q == StSort) && !sort_issued_q;
    busy       = (state_q != StIdle) && (state_q != StDone);
    done       = (state_q == StDone);
    converged  = conv_q;
    stall_err  = stall_q;
    iter_count = iter_q;
  end

endmodule
